// File: rtl/sprite_scheduler.sv
// Frame-tick driven scheduler that grants one VGA pixel-write port to N sprite
// engines in turn, launching each with a one-cycle enable and waiting for its done.
module sprite_scheduler #(
    parameter int N        = 4,
    parameter int TICK_DIV = 833333,
    parameter int TIMEOUT  = 1048575
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             pause,
    input  logic [N-1:0]     active_mask,
    input  logic [N-1:0]     done,
    input  logic [N-1:0]     plot_in,
    input  logic [8*N-1:0]   x_in,
    input  logic [7*N-1:0]   y_in,
    input  logic [3*N-1:0]   colour_in,
    output logic [N-1:0]     en,
    output logic             plot,
    output logic [7:0]       x,
    output logic [6:0]       y,
    output logic [2:0]       colour,
    output logic             busy,
    output logic [2:0]       cur_id,
    output logic             frame_done,
    output logic             overrun,
    output logic             timeout_err,
    output logic [2:0]       dbg_state
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_ADVANCE   = 3'd3,
        S_FRAME_END = 3'd4
    } state_t;

    state_t          state, state_nx;
    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic [WW-1:0]   wait_cnt;
    logic [N-1:0]    frame_mask;
    logic [2:0]      cur_q, cur_nx;
    logic [IW-1:0]   cur_idx;
    logic            overrun_q, timeout_q;
    logic            timeout_set;
    logic            done_cur;
    logic [3:0]      pick;

    // Returns {found, index} of the lowest set bit of m at or above position from.
    function automatic logic [3:0] pick_from(input logic [N-1:0] m, input int from);
        logic [3:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (m[i] && (i >= from)) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    assign cur_idx = cur_q[IW-1:0];

    // tick is registered, so it is high the cycle after the counter reaches TICK_DIV-1.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            tick <= (tick_cnt == TW'(TICK_DIV - 1));
            if (tick_cnt == TW'(TICK_DIV - 1)) tick_cnt <= '0;
            else                               tick_cnt <= tick_cnt + TW'(1);
        end
    end

    always_comb begin
        done_cur = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (cur_idx == IW'(i)) done_cur = done[i];
        end
    end

    // Engine handshake: en[i] is a one-cycle launch; the engine answers with done[i]
    // (any width), which is only observed while that engine holds the grant.
    always_comb begin
        state_nx    = state;
        cur_nx      = cur_q;
        timeout_set = 1'b0;
        pick        = '0;
        unique case (state)
            S_IDLE: begin
                if (tick && !pause) begin
                    if (|active_mask) begin
                        pick     = pick_from(active_mask, 0);
                        cur_nx   = pick[2:0];
                        state_nx = S_LAUNCH;
                    end else begin
                        state_nx = S_FRAME_END;
                    end
                end
            end
            S_LAUNCH: state_nx = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (done_cur) begin
                    state_nx = S_ADVANCE;
                end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
                    timeout_set = 1'b1;
                    state_nx    = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                pick = pick_from(frame_mask, int'(cur_q) + 1);
                if (pick[3]) begin
                    cur_nx   = pick[2:0];
                    state_nx = S_LAUNCH;
                end else begin
                    state_nx = S_FRAME_END;
                end
            end
            S_FRAME_END: state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            cur_q      <= '0;
            wait_cnt   <= '0;
            frame_mask <= '0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state <= state_nx;
            cur_q <= cur_nx;
            if (state == S_IDLE && tick && !pause) frame_mask <= active_mask;
            if (state == S_LAUNCH)         wait_cnt <= '0;
            else if (state == S_WAIT_DONE) wait_cnt <= wait_cnt + WW'(1);
            if (tick && state != S_IDLE) overrun_q <= 1'b1;
            if (timeout_set)             timeout_q <= 1'b1;
        end
    end

    always_comb begin
        en = '0;
        for (int i = 0; i < N; i++) begin
            en[i] = (state == S_LAUNCH) && (cur_idx == IW'(i));
        end
    end

    // Pixel port is a pure combinational mux, live only while the grantee runs.
    always_comb begin
        plot   = 1'b0;
        x      = '0;
        y      = '0;
        colour = '0;
        if (state == S_WAIT_DONE) begin
            for (int i = 0; i < N; i++) begin
                if (cur_idx == IW'(i)) begin
                    plot   = plot_in[i];
                    x      = x_in[8*i +: 8];
                    y      = y_in[7*i +: 7];
                    colour = colour_in[3*i +: 3];
                end
            end
        end
    end

    assign busy        = (state != S_IDLE);
    assign frame_done  = (state == S_FRAME_END);
    assign cur_id      = cur_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_q;
    assign dbg_state   = state;

endmodule

// File: tb/tb_sprite_scheduler.sv
// Bench for sprite_scheduler: behavioural engines, a timeline reference model
// of the frame schedule, a per-cycle compare process and a few pinned literals.
module tb_sprite_scheduler;

  localparam int N  = 4;
  localparam int TD = 40;
  localparam int TO = 8;
  localparam int XW = 8 * N;
  localparam int YW = 7 * N;
  localparam int CW = 3 * N;

  logic          clk;
  logic          resetn;
  logic          pause;
  logic [N-1:0]  active_mask;
  logic [N-1:0]  done;
  logic [N-1:0]  plot_in;
  logic [XW-1:0] x_in;
  logic [YW-1:0] y_in;
  logic [CW-1:0] colour_in;
  logic [N-1:0]  en;
  logic          plot;
  logic [7:0]    x;
  logic [6:0]    y;
  logic [2:0]    colour;
  logic          busy;
  logic [2:0]    cur_id;
  logic          frame_done;
  logic          overrun;
  logic          timeout_err;
  logic [2:0]    dbg_state;

  sprite_scheduler #(.N(N), .TICK_DIV(TD), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .pause(pause), .active_mask(active_mask),
    .done(done), .plot_in(plot_in), .x_in(x_in), .y_in(y_in),
    .colour_in(colour_in), .en(en), .plot(plot), .x(x), .y(y),
    .colour(colour), .busy(busy), .cur_id(cur_id), .frame_done(frame_done),
    .overrun(overrun), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // stimulus configuration
  int           dly [N];
  bit           rnd_mode;
  bit           noise;
  logic [N-1:0] mask_cfg;
  bit           pause_cfg;

  // model outputs for the current cycle
  int           c;
  logic [N-1:0] e_en;
  bit           e_busy, e_fd, e_ovr, e_tmo, e_mux, tmo_pending;
  int           e_cur;

  // first-event monitors (cycle index after reset release, -1 = never)
  int f_en [N];
  int m_en [N];
  int f_fd, m_fd, f_tmo, m_tmo, f_ovr, m_ovr, fd_cnt, m_fd_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_first(input string name, input int dut_v, input int mdl_v, input int lit);
    chk({name, "_dut"}, dut_v, lit);
    chk({name, "_model"}, mdl_v, lit);
  endtask

  task automatic clear_first();
    for (int i = 0; i < N; i++) begin
      f_en[i] = -1;
      m_en[i] = -1;
    end
    f_fd = -1; m_fd = -1; f_tmo = -1; m_tmo = -1; f_ovr = -1; m_ovr = -1;
    fd_cnt = 0; m_fd_cnt = 0;
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_tick();
    return (c > 0) && (c % TD == 0);
  endfunction

  task automatic reset_model();
    c = -1; e_en = '0; e_busy = 0; e_fd = 0; e_ovr = 0; e_tmo = 0;
    e_mux = 0; tmo_pending = 0; e_cur = 0;
  endtask

  task automatic step(output bit ab);
    bit ovr_n, tmo_n;
    ovr_n = e_ovr | (is_tick() & e_busy);
    tmo_n = e_tmo | tmo_pending;
    tmo_pending = 0;
    @(negedge clk);
    if (!resetn) begin
      reset_model();
      ab = 1;
    end else begin
      c++;
      e_ovr = ovr_n;
      e_tmo = tmo_n;
      ab = 0;
    end
  endtask

  task automatic run_frame(input logic [N-1:0] fm);
    bit ab, got;
    for (int i = 0; i < N; i++) begin
      if (fm[i]) begin
        e_busy = 1; e_cur = i; e_en = N'(1) << i; e_mux = 0; e_fd = 0;
        step(ab);
        if (ab) return;
        e_en = '0; e_mux = 1;
        for (int w = 0; w < TO; w++) begin
          got = done[i];
          if (!got && w == TO - 1) tmo_pending = 1;
          step(ab);
          if (ab) return;
          if (got) break;
        end
        e_mux = 0;
        step(ab);
        if (ab) return;
      end
    end
    e_en = '0; e_mux = 0; e_busy = 1; e_fd = 1;
    step(ab);
  endtask

  initial begin : model
    bit ab, start;
    logic [N-1:0] fm;
    reset_model();
    @(negedge clk);
    forever begin
      e_en = '0; e_busy = 0; e_fd = 0; e_mux = 0;
      start = resetn && is_tick() && !pause;
      fm = active_mask;
      step(ab);
      if (!ab && start) run_frame(fm);
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : compare
    logic       ep;
    logic [7:0] ex;
    logic [6:0] ey;
    logic [2:0] ec;
    forever begin
      @(negedge clk);
      #1;
      ep = 0; ex = 0; ey = 0; ec = 0;
      if (e_mux) begin
        ep = plot_in[e_cur];
        ex = x_in[8*e_cur +: 8];
        ey = y_in[7*e_cur +: 7];
        ec = colour_in[3*e_cur +: 3];
      end
      chk("en", en, e_en);
      chk("plot", plot, ep);
      chk("x", x, ex);
      chk("y", y, ey);
      chk("colour", colour, ec);
      chk("busy", busy, e_busy);
      chk("cur_id", cur_id, e_cur);
      chk("frame_done", frame_done, e_fd);
      chk("overrun", overrun, e_ovr);
      chk("timeout_err", timeout_err, e_tmo);
    end
  end

  // ---------------- first-event monitor ----------------
  initial begin : monitor
    forever begin
      @(negedge clk);
      #2;
      if (resetn) begin
        for (int i = 0; i < N; i++) begin
          if (f_en[i] < 0 && en[i])   f_en[i] = c;
          if (m_en[i] < 0 && e_en[i]) m_en[i] = c;
        end
        if (f_fd < 0 && frame_done)   f_fd = c;
        if (m_fd < 0 && e_fd)         m_fd = c;
        if (f_tmo < 0 && timeout_err) f_tmo = c;
        if (m_tmo < 0 && e_tmo)       m_tmo = c;
        if (f_ovr < 0 && overrun)     f_ovr = c;
        if (m_ovr < 0 && e_ovr)       m_ovr = c;
        if (frame_done) fd_cnt++;
        if (e_fd)       m_fd_cnt++;
      end
    end
  end

  // ---------------- engine and input driver ----------------
  initial begin : driver
    int rem [N];
    int hc [N];
    logic [N-1:0] en_seen, nd;
    pause = 0; active_mask = '0; done = '0; plot_in = '0;
    x_in = '0; y_in = '0; colour_in = '0;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      hc[i] = 0;
    end
    forever begin
      @(negedge clk);
      en_seen = en;
      @(posedge clk);
      #1;
      plot_in   = N'($urandom);
      x_in      = XW'($urandom);
      y_in      = YW'($urandom);
      colour_in = CW'($urandom);
      if (rnd_mode) begin
        if ($urandom_range(0, 29) == 0) active_mask = N'($urandom);
        if ($urandom_range(0, 49) == 0) pause = ~pause;
      end else begin
        active_mask = mask_cfg;
        pause = pause_cfg;
      end
      for (int i = 0; i < N; i++) begin
        if (!resetn) begin
          rem[i] = 0;
          hc[i] = 0;
        end else if (en_seen[i]) begin
          rem[i] = rnd_mode ? int'($urandom_range(0, 10)) : dly[i];
        end
        if (rem[i] > 0) begin
          rem[i]--;
          if (rem[i] == 0) hc[i] = rnd_mode ? int'($urandom_range(1, 3)) : 1;
        end
        nd[i] = (hc[i] > 0) || (noise && $urandom_range(0, 19) == 0);
        if (hc[i] > 0) hc[i]--;
      end
      done = nd;
    end
  end

  // ---------------- scenarios ----------------
  task automatic do_reset();
    @(posedge clk);
    #2 resetn = 0;
    repeat (3) @(posedge clk);
    #1 resetn = 1;
    clear_first();
  endtask

  task automatic set_cfg(input logic [N-1:0] m, input int d0, input int d1,
                         input int d2, input int d3);
    mask_cfg = m; pause_cfg = 0; rnd_mode = 0; noise = 0;
    dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
    #3;
  endtask

  initial begin : main
    resetn = 0;
    clear_first();
    set_cfg(4'hF, 5, 5, 5, 5);
    repeat (2) @(negedge clk);
    #3;
    chk("rst_en", en, 0);
    chk("rst_plot", plot, 0);
    chk("rst_xyc", {x, y, colour}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {frame_done, overrun, timeout_err}, 0);
    chk("rst_cur_id", cur_id, 0);

    // all four engines, 5-cycle runtime
    do_reset();
    run_cycles(100);
    chk_first("s1_en0", f_en[0], m_en[0], 41);
    chk_first("s1_en1", f_en[1], m_en[1], 48);
    chk_first("s1_en2", f_en[2], m_en[2], 55);
    chk_first("s1_en3", f_en[3], m_en[3], 62);
    chk_first("s1_fd", f_fd, m_fd, 69);
    chk("s1_overrun", overrun, 0);

    // sparse mask 1010
    set_cfg(4'b1010, 3, 3, 3, 3);
    do_reset();
    run_cycles(100);
    chk_first("s2_en0", f_en[0], m_en[0], -1);
    chk_first("s2_en1", f_en[1], m_en[1], 41);
    chk_first("s2_en2", f_en[2], m_en[2], -1);
    chk_first("s2_en3", f_en[3], m_en[3], 46);
    chk_first("s2_fd", f_fd, m_fd, 51);

    // empty mask
    set_cfg(4'b0000, 5, 5, 5, 5);
    do_reset();
    run_cycles(100);
    chk_first("s3_en0", f_en[0], m_en[0], -1);
    chk_first("s3_fd", f_fd, m_fd, 41);
    chk_first("s3_fd_cnt", fd_cnt, m_fd_cnt, 2);

    // engine 2 never finishes
    set_cfg(4'hF, 5, 5, 0, 5);
    do_reset();
    run_cycles(100);
    chk_first("s4_tmo", f_tmo, m_tmo, 64);
    chk_first("s4_en3", f_en[3], m_en[3], 65);
    chk_first("s4_fd", f_fd, m_fd, 72);

    // done on the last allowed wait cycle beats the timeout
    set_cfg(4'b0100, 8, 8, 8, 8);
    do_reset();
    run_cycles(70);
    chk_first("s5_fd", f_fd, m_fd, 51);
    chk_first("s5_tmo", f_tmo, m_tmo, -1);

    // every engine times out: frame overruns the next tick
    set_cfg(4'hF, 0, 0, 0, 0);
    do_reset();
    run_cycles(150);
    chk_first("s6_tmo", f_tmo, m_tmo, 50);
    chk_first("s6_ovr", f_ovr, m_ovr, 81);
    chk_first("s6_fd", f_fd, m_fd, 81);
    chk_first("s6_fd_cnt", fd_cnt, m_fd_cnt, 1);

    // reset while engine 1 is being waited on
    set_cfg(4'hF, 5, 5, 5, 5);
    do_reset();
    for (int k = 0; k < 200 && c != 50; k++) @(negedge clk);
    chk("s7_reach", c, 50);
    chk("s7_pre_cur", cur_id, 1);
    @(posedge clk);
    #2 resetn = 0;
    #1;
    chk("s7_rst_busy", busy, 0);
    chk("s7_rst_en", en, 0);
    chk("s7_rst_pix", {plot, x, y, colour}, 0);
    chk("s7_rst_cur", cur_id, 0);
    repeat (3) @(posedge clk);
    #1 resetn = 1;
    clear_first();
    run_cycles(60);
    chk_first("s7_en0", f_en[0], m_en[0], 41);

    // randomized traffic with periodic resets
    rnd_mode = 1; noise = 1;
    for (int r = 0; r < 5; r++) begin
      do_reset();
      run_cycles(700);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
